// File: rtl/regfile_670_pkg.sv
// Shared definitions for the two-requester register-file controller:
// FSM state encoding, default strobe widths and the strobe-counter load helper.
package regfile_670_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_SETUP   = 3'd1,
        W_STROBE  = 3'd2,
        W_HOLD    = 3'd3,
        R_ACCESS  = 3'd4,
        R_CAPTURE = 3'd5
    } state_e;

    localparam int WE_CYCLES_DEF = 2;
    localparam int RD_CYCLES_DEF = 2;

    // Counter load value: the counter runs from cycles-1 down to zero.
    function automatic logic [3:0] strobe_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/regfile_670_ctl_if.sv
// Requester-side bus of the register-file controller (two requesters, A and B).
interface regfile_670_ctl_if;
    logic       req_a;
    logic       req_b;
    logic       wr_a;
    logic       wr_b;
    logic [1:0] addr_a;
    logic [1:0] addr_b;
    logic [3:0] wdata_a;
    logic [3:0] wdata_b;
    logic       ack_a;
    logic       ack_b;
    logic [3:0] rdata;

    modport master (
        output req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b,
        input  ack_a, ack_b, rdata
    );

    modport slave (
        input  req_a, req_b, wr_a, wr_b, addr_a, addr_b, wdata_a, wdata_b,
        output ack_a, ack_b, rdata
    );
endinterface

// File: rtl/regfile_670_ctl_chk.sv
// Protocol checker for the regfile strobes; instantiated alongside the controller.
module regfile_670_ctl_chk (
    input logic clk,
    input logic reset,
    input logic rf_we_n,
    input logic rf_re_n,
    input logic rf_d_oe
);
    a_no_strobe_overlap: assert property (@(posedge clk) disable iff (reset)
        !(!rf_we_n && !rf_re_n))
        else $error("rf_we_n and rf_re_n low together");

    a_we_drives_bus: assert property (@(posedge clk) disable iff (reset)
        !rf_we_n |-> rf_d_oe)
        else $error("write strobe without data drive");
endmodule

// File: rtl/regfile_670_ctl_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer advances when the
// controller accepts a request. After reset requester A (bit 0) is favoured.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic favour_b_r;

    // Grant selection: a lone request wins outright, a tie goes to the favoured side.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            if (favour_b_r) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

    // Pointer update: after granting A, B is favoured next time, and vice versa.
    always_ff @(posedge clk) begin
        if (reset) begin
            favour_b_r <= 1'b0;
        end else if (advance) begin
            favour_b_r <= grant[0];
        end else begin
            favour_b_r <= favour_b_r;
        end
    end
endmodule

// File: rtl/regfile_670_ctl.sv
// Two-requester register-file access controller. One FSM sequences write
// (setup / strobe / hold) and read (access / capture) cycles; every regfile
// strobe and handshake output comes straight from a flop.
module regfile_670_ctl
    import regfile_670_pkg::*;
#(
    parameter int WE_CYCLES = WE_CYCLES_DEF,
    parameter int RD_CYCLES = RD_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    regfile_670_ctl_if.slave  bus,
    output logic [3:0]        rf_d,
    output logic              rf_d_oe,
    output logic [1:0]        rf_wa,
    output logic [1:0]        rf_ra,
    output logic              rf_we_n,
    output logic              rf_re_n,
    input  logic [3:0]        rf_q
);
    state_e     state_r, state_s;
    logic [3:0] cnt_r;
    logic       grant_b_r;
    logic [1:0] req_s, gnt_s;
    logic       adv_s, op_wr_s;
    logic [1:0] sel_addr_s;
    logic [3:0] sel_wdata_s;
    logic       we_n_s, re_n_s, oe_s, ack_a_s, ack_b_s;
    logic       we_n_r, re_n_r, oe_r, ack_a_r, ack_b_r;
    logic [3:0] rdata_r, rf_d_r;
    logic [1:0] rf_wa_r, rf_ra_r;

    assign req_s = {bus.req_b, bus.req_a};
    assign adv_s = (state_r == IDLE) && (req_s != 2'b00);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_s),
        .advance (adv_s),
        .grant   (gnt_s)
    );

    // Operation fields of whichever requester the arbiter is granting.
    always_comb begin
        op_wr_s     = 1'b0;
        sel_addr_s  = 2'd0;
        sel_wdata_s = 4'd0;
        if (gnt_s[1]) begin
            op_wr_s     = bus.wr_b;
            sel_addr_s  = bus.addr_b;
            sel_wdata_s = bus.wdata_b;
        end else begin
            op_wr_s     = bus.wr_a;
            sel_addr_s  = bus.addr_a;
            sel_wdata_s = bus.wdata_a;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the strobe phases end when the down-counter reaches zero.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (adv_s) begin
                    if (op_wr_s) begin
                        state_s = W_SETUP;
                    end else begin
                        state_s = R_ACCESS;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            W_SETUP:  state_s = W_STROBE;
            W_STROBE: begin
                if (cnt_r == 4'd0) begin
                    state_s = W_HOLD;
                end else begin
                    state_s = W_STROBE;
                end
            end
            W_HOLD:   state_s = IDLE;
            R_ACCESS: begin
                if (cnt_r == 4'd0) begin
                    state_s = R_CAPTURE;
                end else begin
                    state_s = R_ACCESS;
                end
            end
            R_CAPTURE: state_s = IDLE;
            default:   state_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state, so the flops below present it in step with state_r.
    always_comb begin
        we_n_s  = 1'b1;
        re_n_s  = 1'b1;
        oe_s    = 1'b0;
        ack_a_s = 1'b0;
        ack_b_s = 1'b0;
        case (state_s)
            W_SETUP:  oe_s = 1'b1;
            W_STROBE: begin
                oe_s   = 1'b1;
                we_n_s = 1'b0;
            end
            W_HOLD: begin
                oe_s    = 1'b1;
                ack_a_s = !grant_b_r;
                ack_b_s = grant_b_r;
            end
            R_ACCESS: re_n_s = 1'b0;
            R_CAPTURE: begin
                ack_a_s = !grant_b_r;
                ack_b_s = grant_b_r;
            end
            default: begin
                oe_s = 1'b0;
            end
        endcase
    end

    // Registered strobes, bus drive enable and acknowledges.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_n_r  <= 1'b1;
            re_n_r  <= 1'b1;
            oe_r    <= 1'b0;
            ack_a_r <= 1'b0;
            ack_b_r <= 1'b0;
        end else begin
            we_n_r  <= we_n_s;
            re_n_r  <= re_n_s;
            oe_r    <= oe_s;
            ack_a_r <= ack_a_s;
            ack_b_r <= ack_b_s;
        end
    end

    // Grant-time latching of owner/address/data, strobe counting and read capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_b_r <= 1'b0;
            cnt_r     <= 4'd0;
            rdata_r   <= 4'd0;
            rf_wa_r   <= 2'd0;
            rf_ra_r   <= 2'd0;
            rf_d_r    <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (adv_s) begin
                        grant_b_r <= gnt_s[1];
                        if (op_wr_s) begin
                            cnt_r   <= strobe_load(WE_CYCLES);
                            rf_wa_r <= sel_addr_s;
                            rf_d_r  <= sel_wdata_s;
                        end else begin
                            cnt_r   <= strobe_load(RD_CYCLES);
                            rf_ra_r <= sel_addr_s;
                        end
                    end
                end
                W_STROBE: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                R_ACCESS: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        rdata_r <= rf_q;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign rf_we_n   = we_n_r;
    assign rf_re_n   = re_n_r;
    assign rf_d_oe   = oe_r;
    assign rf_d      = rf_d_r;
    assign rf_wa     = rf_wa_r;
    assign rf_ra     = rf_ra_r;
    assign bus.ack_a = ack_a_r;
    assign bus.ack_b = ack_b_r;
    assign bus.rdata = rdata_r;
endmodule

// File: tb/tb_regfile_670_ctl.sv
// Bench for regfile_670_ctl: a behavioural 4x4 register file answers the
// controller, and a reference model (array of contents + last-granted side +
// latency rules) predicts acks, read data, strobe widths and grant order.
module tb_regfile_670_ctl;
    import regfile_670_pkg::*;

    localparam int WE = WE_CYCLES_DEF;
    localparam int RD = RD_CYCLES_DEF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    regfile_670_ctl_if bus();
    regfile_670_ctl_if bus1();
    regfile_670_ctl_if bus15();

    logic [3:0] rf_d, rf_q;
    logic       rf_d_oe, rf_we_n, rf_re_n;
    logic [1:0] rf_wa, rf_ra;

    logic [3:0] s1_d, s15_d;
    logic       s1_oe, s1_we_n, s1_re_n, s15_oe, s15_we_n, s15_re_n;
    logic [1:0] s1_wa, s1_ra, s15_wa, s15_ra;
    logic [3:0] sweep_q = 4'h3;

    regfile_670_ctl u_dut (
        .clk(clk), .reset(reset), .bus(bus),
        .rf_d(rf_d), .rf_d_oe(rf_d_oe), .rf_wa(rf_wa), .rf_ra(rf_ra),
        .rf_we_n(rf_we_n), .rf_re_n(rf_re_n), .rf_q(rf_q)
    );
    regfile_670_ctl #(.WE_CYCLES(1)) u_we1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .rf_d(s1_d), .rf_d_oe(s1_oe), .rf_wa(s1_wa), .rf_ra(s1_ra),
        .rf_we_n(s1_we_n), .rf_re_n(s1_re_n), .rf_q(sweep_q)
    );
    regfile_670_ctl #(.WE_CYCLES(15)) u_we15 (
        .clk(clk), .reset(reset), .bus(bus15),
        .rf_d(s15_d), .rf_d_oe(s15_oe), .rf_wa(s15_wa), .rf_ra(s15_ra),
        .rf_we_n(s15_we_n), .rf_re_n(s15_re_n), .rf_q(sweep_q)
    );

    regfile_670_ctl_chk u_chk   (.clk(clk), .reset(reset), .rf_we_n(rf_we_n),  .rf_re_n(rf_re_n),  .rf_d_oe(rf_d_oe));
    regfile_670_ctl_chk u_chk1  (.clk(clk), .reset(reset), .rf_we_n(s1_we_n),  .rf_re_n(s1_re_n),  .rf_d_oe(s1_oe));
    regfile_670_ctl_chk u_chk15 (.clk(clk), .reset(reset), .rf_we_n(s15_we_n), .rf_re_n(s15_re_n), .rf_d_oe(s15_oe));

    // Behavioural register file attached to the main controller.
    logic [3:0] rf_mem [4];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= 4'h0;
        end else if (!rf_we_n) begin
            rf_mem[rf_wa] <= rf_d;
        end
    end
    assign rf_q = rf_mem[rf_ra];

    // Strobe-overlap monitor across all three controllers.
    int overlap_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if ((!rf_we_n && !rf_re_n) || (!s1_we_n && !s1_re_n) || (!s15_we_n && !s15_re_n))
                overlap_cnt <= overlap_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_pass = 0;
    logic [3:0] model_mem [4];
    bit model_last_b = 1'b1;  // reset state: A favoured, as if B was granted last

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request on the main bus; counts strobes until the granted side acks.
    task automatic run_op(input bit side_b, input bit wr, input logic [1:0] addr,
                          input logic [3:0] data, input bit hold_req,
                          output int lat, output int we_low, output int re_low,
                          output int oe_high, output bit got_ack, output bit wrong_ack,
                          output logic [3:0] rd);
        lat = 0; we_low = 0; re_low = 0; oe_high = 0;
        got_ack = 1'b0; wrong_ack = 1'b0; rd = 4'h0;
        if (side_b) begin
            bus.wr_b = wr; bus.addr_b = addr; bus.wdata_b = data; bus.req_b = 1'b1;
        end else begin
            bus.wr_a = wr; bus.addr_a = addr; bus.wdata_a = data; bus.req_a = 1'b1;
        end
        for (int c = 1; c <= 40 && !got_ack; c++) begin
            step();
            if (!hold_req && c == 2) begin
                bus.req_a = 1'b0;
                bus.req_b = 1'b0;
            end
            if (!rf_we_n) we_low++;
            if (!rf_re_n) re_low++;
            if (rf_d_oe) oe_high++;
            if ((side_b ? bus.ack_b : bus.ack_a) === 1'b1) begin
                got_ack = 1'b1;
                lat = c;
                rd = bus.rdata;
            end
            if ((side_b ? bus.ack_a : bus.ack_b) === 1'b1) wrong_ack = 1'b1;
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        if (got_ack) begin
            model_last_b = side_b;
            if (wr) model_mem[addr] = data;
        end
        step();
    endtask

    task automatic test_reset();
        bus.req_a = 0; bus.req_b = 0; bus.wr_a = 0; bus.wr_b = 0;
        bus.addr_a = 0; bus.addr_b = 0; bus.wdata_a = 0; bus.wdata_b = 0;
        bus1.req_a = 0; bus1.req_b = 0; bus1.wr_a = 0; bus1.wr_b = 0;
        bus1.addr_a = 0; bus1.addr_b = 0; bus1.wdata_a = 0; bus1.wdata_b = 0;
        bus15.req_a = 0; bus15.req_b = 0; bus15.wr_a = 0; bus15.wr_b = 0;
        bus15.addr_a = 0; bus15.addr_b = 0; bus15.wdata_a = 0; bus15.wdata_b = 0;
        for (int i = 0; i < 4; i++) model_mem[i] = 4'h0;
        reset = 1'b1; mem_clr = 1'b1;
        step(); step(); step();
        n_checks++; if (rf_we_n !== 1'b1) $display("FAIL reset_we_n got %b want 1", rf_we_n); else n_pass++;
        n_checks++; if (rf_re_n !== 1'b1) $display("FAIL reset_re_n got %b want 1", rf_re_n); else n_pass++;
        n_checks++; if (rf_d_oe !== 1'b0) $display("FAIL reset_oe got %b want 0", rf_d_oe); else n_pass++;
        n_checks++; if ({bus.ack_a, bus.ack_b} !== 2'b00) $display("FAIL reset_ack got %b want 00", {bus.ack_a, bus.ack_b}); else n_pass++;
        n_checks++; if (bus.rdata !== 4'h0) $display("FAIL reset_rdata got %h want 0", bus.rdata); else n_pass++;
        n_checks++; if ({rf_wa, rf_ra, rf_d} !== 8'h00) $display("FAIL reset_addr_data got %h want 00", {rf_wa, rf_ra, rf_d}); else n_pass++;
        reset = 1'b0; mem_clr = 1'b0;
        model_last_b = 1'b1;
        step();
    endtask

    task automatic test_write_basic();
        int lat, wl, rl, oh; bit ga, wa; logic [3:0] rd;
        run_op(1'b0, 1'b1, 2'd2, 4'h5, 1'b1, lat, wl, rl, oh, ga, wa, rd);
        n_checks++; if (!ga || lat != WE + 2) $display("FAIL wr_ack_latency got %0d (ack %b) want %0d", lat, ga, WE + 2); else n_pass++;
        n_checks++; if (wl != WE) $display("FAIL wr_we_width got %0d want %0d", wl, WE); else n_pass++;
        n_checks++; if (oh != WE + 2) $display("FAIL wr_oe_width got %0d want %0d", oh, WE + 2); else n_pass++;
        n_checks++; if (wa || rl != 0) $display("FAIL wr_side_effects wrong_ack %b re_low %0d want 0 0", wa, rl); else n_pass++;
        n_checks++; if (rf_mem[2] !== 4'h5) $display("FAIL wr_regfile_data got %h want 5", rf_mem[2]); else n_pass++;
        n_checks++; if (rf_d_oe !== 1'b0) $display("FAIL wr_oe_released got %b want 0", rf_d_oe); else n_pass++;
    endtask

    task automatic test_read_b();
        int lat, wl, rl, oh; bit ga, wa; logic [3:0] rd;
        run_op(1'b0, 1'b1, 2'd1, 4'hA, 1'b1, lat, wl, rl, oh, ga, wa, rd);
        run_op(1'b1, 1'b0, 2'd1, 4'h0, 1'b1, lat, wl, rl, oh, ga, wa, rd);
        n_checks++; if (!ga || lat != RD + 1) $display("FAIL rd_ack_latency got %0d (ack %b) want %0d", lat, ga, RD + 1); else n_pass++;
        n_checks++; if (rl != RD) $display("FAIL rd_re_width got %0d want %0d", rl, RD); else n_pass++;
        n_checks++; if (wl != 0 || oh != 0) $display("FAIL rd_no_write we_low %0d oe %0d want 0 0", wl, oh); else n_pass++;
        n_checks++; if (rd !== model_mem[1]) $display("FAIL rd_data got %h want %h", rd, model_mem[1]); else n_pass++;
        step(); step();
        n_checks++; if (bus.rdata !== model_mem[1]) $display("FAIL rd_data_hold got %h want %h", bus.rdata, model_mem[1]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ack_cyc[$];
        bit ack_side[$];
        bit exp_side;
        int ov = 0;
        bus.wr_a = 1; bus.addr_a = 2'd0; bus.wdata_a = 4'h6;
        bus.wr_b = 1; bus.addr_b = 2'd3; bus.wdata_b = 4'h9;
        bus.req_a = 1; bus.req_b = 1;
        for (int c = 1; c <= 80 && ack_cyc.size() < 4; c++) begin
            step();
            if (bus.ack_a && bus.ack_b) ov++;
            if (bus.ack_a === 1'b1) begin ack_cyc.push_back(c); ack_side.push_back(1'b0); end
            else if (bus.ack_b === 1'b1) begin ack_cyc.push_back(c); ack_side.push_back(1'b1); end
        end
        bus.req_a = 0; bus.req_b = 0;
        step();
        n_checks++; if (ack_cyc.size() != 4) $display("FAIL b2b_ack_count got %0d want 4", ack_cyc.size()); else n_pass++;
        n_checks++; if (ov != 0) $display("FAIL b2b_ack_overlap got %0d want 0", ov); else n_pass++;
        for (int k = 0; k < ack_cyc.size(); k++) begin
            exp_side = !model_last_b;
            n_checks++; if (ack_side[k] !== exp_side) $display("FAIL b2b_order[%0d] got %s want %s", k, ack_side[k] ? "B" : "A", exp_side ? "B" : "A"); else n_pass++;
            model_last_b = exp_side;
            if (exp_side) model_mem[3] = 4'h9; else model_mem[0] = 4'h6;
            if (k > 0) begin
                n_checks++; if (ack_cyc[k] - ack_cyc[k-1] != WE + 3) $display("FAIL b2b_spacing[%0d] got %0d want %0d", k, ack_cyc[k] - ack_cyc[k-1], WE + 3); else n_pass++;
            end
        end
        n_checks++; if (rf_mem[0] !== 4'h6 || rf_mem[3] !== 4'h9) $display("FAIL b2b_regfile got %h %h want 6 9", rf_mem[0], rf_mem[3]); else n_pass++;
    endtask

    task automatic test_drop();
        int lat, wl, rl, oh; bit ga, wa; logic [3:0] rd;
        run_op(1'b0, 1'b0, 2'd3, 4'h0, 1'b0, lat, wl, rl, oh, ga, wa, rd);
        n_checks++; if (!ga || lat != RD + 1 || rd !== model_mem[3]) $display("FAIL drop_read ack %b lat %0d data %h want 1 %0d %h", ga, lat, rd, RD + 1, model_mem[3]); else n_pass++;
        run_op(1'b1, 1'b1, 2'd2, 4'hC, 1'b0, lat, wl, rl, oh, ga, wa, rd);
        n_checks++; if (!ga || lat != WE + 2 || wl != WE) $display("FAIL drop_write ack %b lat %0d we %0d want 1 %0d %0d", ga, lat, wl, WE + 2, WE); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, wl, rl, oh; bit ga, wa; logic [3:0] rd;
        bit seen = 1'b0;
        bus.wr_a = 1; bus.addr_a = 2'd0; bus.wdata_a = 4'hF; bus.req_a = 1;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            if (rf_we_n === 1'b0) seen = 1'b1;
        end
        n_checks++; if (!seen) $display("FAIL mid_reach_strobe got 0 want 1"); else n_pass++;
        reset = 1'b1; bus.req_a = 0;
        step();
        n_checks++; if (rf_we_n !== 1'b1 || rf_d_oe !== 1'b0) $display("FAIL mid_reset_outputs we_n %b oe %b want 1 0", rf_we_n, rf_d_oe); else n_pass++;
        n_checks++; if ({bus.ack_a, bus.ack_b} !== 2'b00) $display("FAIL mid_reset_ack got %b want 00", {bus.ack_a, bus.ack_b}); else n_pass++;
        reset = 1'b0; model_last_b = 1'b1;
        step(); step();
        n_checks++; if (bus.ack_a !== 1'b0) $display("FAIL mid_no_late_ack got %b want 0", bus.ack_a); else n_pass++;
        run_op(1'b0, 1'b1, 2'd0, 4'h1, 1'b1, lat, wl, rl, oh, ga, wa, rd);
        n_checks++; if (!ga || lat != WE + 2) $display("FAIL mid_restart ack %b lat %0d want 1 %0d", ga, lat, WE + 2); else n_pass++;
    endtask

    task automatic test_random();
        int lat, wl, rl, oh; bit ga, wa; logic [3:0] rd;
        bit sb, wr, hold; logic [1:0] ad; logic [3:0] dt;
        for (int n = 0; n < 30; n++) begin
            sb = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            ad = 2'($urandom_range(0, 3));
            dt = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 3) != 0);
            run_op(sb, wr, ad, dt, hold, lat, wl, rl, oh, ga, wa, rd);
            n_checks++; if (!ga || wa) $display("FAIL rnd_ack[%0d] ack %b wrong %b want 1 0", n, ga, wa); else n_pass++;
            n_checks++; if (lat != (wr ? WE + 2 : RD + 1)) $display("FAIL rnd_latency[%0d] got %0d want %0d", n, lat, wr ? WE + 2 : RD + 1); else n_pass++;
            n_checks++; if (wl != (wr ? WE : 0) || rl != (wr ? 0 : RD)) $display("FAIL rnd_strobes[%0d] we %0d re %0d", n, wl, rl); else n_pass++;
            if (!wr) begin
                n_checks++; if (rd !== model_mem[ad]) $display("FAIL rnd_rdata[%0d] got %h want %h", n, rd, model_mem[ad]); else n_pass++;
            end
        end
    endtask

    task automatic test_sweep();
        int w1 = 0, w15 = 0, l1 = 0, l15 = 0;
        bus1.wr_a = 1; bus1.addr_a = 2'd2; bus1.wdata_a = 4'h7; bus1.req_a = 1;
        bus15.wr_a = 1; bus15.addr_a = 2'd2; bus15.wdata_a = 4'h7; bus15.req_a = 1;
        for (int c = 1; c <= 40 && (l1 == 0 || l15 == 0); c++) begin
            step();
            if (!s1_we_n) w1++;
            if (!s15_we_n) w15++;
            if (bus1.ack_a === 1'b1 && l1 == 0) begin l1 = c; bus1.req_a = 0; end
            if (bus15.ack_a === 1'b1 && l15 == 0) begin l15 = c; bus15.req_a = 0; end
        end
        bus1.req_a = 0; bus15.req_a = 0;
        step();
        n_checks++; if (w1 != 1) $display("FAIL sweep_we1_width got %0d want 1", w1); else n_pass++;
        n_checks++; if (w15 != 15) $display("FAIL sweep_we15_width got %0d want 15", w15); else n_pass++;
        n_checks++; if (l1 != 3) $display("FAIL sweep_we1_latency got %0d want 3", l1); else n_pass++;
        n_checks++; if (l15 != 17) $display("FAIL sweep_we15_latency got %0d want 17", l15); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_b();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_random();
        test_sweep();
        n_checks++; if (overlap_cnt != 0) $display("FAIL strobe_overlap got %0d cycles want 0", overlap_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
